// File: rtl/frame_pacer.sv
// Frame-timing generator: reprogrammable cycle divider, frame skipper,
// pause/single-step control and a wrapping count of update ticks.
// update_tick is the "advance one game frame" strobe for downstream logic.
module frame_pacer #(
  parameter int CLK_HZ  = 50000000,
  parameter int FPS     = 60,
  parameter int CNT_W   = 21,
  parameter int SKIP_W  = 4,
  parameter int FRAME_W = 16
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               enable,
  input  logic               pause,
  input  logic               step,
  input  logic               period_load,
  input  logic [CNT_W-1:0]   period_in,
  input  logic [SKIP_W-1:0]  skip_count,
  output logic [CNT_W-1:0]   cycle_count,
  output logic               frame_tick,
  output logic               update_tick,
  output logic [SKIP_W-1:0]  frame_count,
  output logic [FRAME_W-1:0] frame_number,
  output logic [CNT_W-1:0]   period_active
);

  // Cycles per frame minus one at the nominal rate.
  localparam logic [CNT_W-1:0] DEFAULT_PERIOD = CNT_W'(CLK_HZ / FPS - 1);

  // Shadow holds a loaded period until the next frame boundary so the
  // frame in progress is never shortened.
  logic [CNT_W-1:0] shadow;
  logic             pending;
  logic             step_q;

  logic             run;
  logic             step_rise;
  logic             frame_event;
  logic             skip_done;
  logic [CNT_W-1:0] active_next;

  // Decode the run condition, the step edge and the frame boundary.
  always_comb begin
    run         = 1'b0;
    step_rise   = 1'b0;
    frame_event = 1'b0;
    skip_done   = 1'b0;
    active_next = period_active;

    run         = enable & ~pause;
    step_rise   = step & ~step_q;
    frame_event = (run && (cycle_count == '0)) || (enable && pause && step_rise);
    skip_done   = (frame_count == '0);
    if (pending) begin
      active_next = shadow;
    end
  end

  // Step edge register tracks the input on every edge, so a step held
  // across a pause toggle or while disabled never produces a late event.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      step_q <= 1'b0;
    end else begin
      step_q <= step;
    end
  end

  // Period shadow: captured regardless of enable/pause; a load on a frame
  // boundary stays pending for the following boundary.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shadow  <= DEFAULT_PERIOD;
      pending <= 1'b0;
    end else if (period_load) begin
      shadow  <= period_in;
      pending <= 1'b1;
    end else if (frame_event) begin
      pending <= 1'b0;
    end
  end

  // Divider down-counter and the active period for the current frame.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cycle_count   <= '0;
      period_active <= DEFAULT_PERIOD;
      frame_tick    <= 1'b0;
    end else begin
      frame_tick <= frame_event;
      if (frame_event) begin
        period_active <= active_next;
        cycle_count   <= active_next;
      end else if (run) begin
        cycle_count <= cycle_count - CNT_W'(1);
      end
    end
  end

  // Frame skipper and wrapping update counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      frame_count  <= '0;
      frame_number <= '0;
      update_tick  <= 1'b0;
    end else begin
      update_tick <= frame_event && skip_done;
      if (frame_event) begin
        if (skip_done) begin
          frame_count  <= skip_count;
          frame_number <= frame_number + FRAME_W'(1);
        end else begin
          frame_count <= frame_count - SKIP_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_pacer.sv
// Directed bench for frame_pacer at a reduced clock (period 9, 4-bit frame
// number). Stimulus pushes the expected tick records; a monitor pops and
// compares one record per observed tick.
module tb_frame_pacer;

  localparam int CW = 8;
  localparam int SW = 4;
  localparam int FW = 4;
  localparam int EW = 32 + 1 + FW + SW + CW + CW;

  logic          clk;
  logic          resetn;
  logic          enable;
  logic          pause;
  logic          step;
  logic          period_load;
  logic [CW-1:0] period_in;
  logic [SW-1:0] skip_count;
  logic [CW-1:0] cycle_count;
  logic          frame_tick;
  logic          update_tick;
  logic [SW-1:0] frame_count;
  logic [FW-1:0] frame_number;
  logic [CW-1:0] period_active;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [EW-1:0] exp_q[$];

  frame_pacer #(
    .CLK_HZ (100),
    .FPS    (10),
    .CNT_W  (CW),
    .SKIP_W (SW),
    .FRAME_W(FW)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .enable       (enable),
    .pause        (pause),
    .step         (step),
    .period_load  (period_load),
    .period_in    (period_in),
    .skip_count   (skip_count),
    .cycle_count  (cycle_count),
    .frame_tick   (frame_tick),
    .update_tick  (update_tick),
    .frame_count  (frame_count),
    .frame_number (frame_number),
    .period_active(period_active)
  );

  // Clock and posedge counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Expected tick record: posedge index, update_tick, frame_number,
  // frame_count, cycle_count, period_active as seen right after the tick edge.
  task automatic push_exp(input int at, input logic upd, input logic [FW-1:0] fn,
                          input logic [SW-1:0] fc, input logic [CW-1:0] cc,
                          input logic [CW-1:0] pa);
    exp_q.push_back({32'(at), upd, fn, fc, cc, pa});
  endtask

  task automatic go_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Monitor: every observed tick must match the head of the expected queue.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic [EW-1:0] a;
    if (frame_tick === 1'b1 || update_tick === 1'b1) begin
      checks++;
      a = {32'(cyc), update_tick, frame_number, frame_count, cycle_count, period_active};
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_tick at cycle %0d frame_tick=%0b update_tick=%0b",
                 cyc, frame_tick, update_tick);
      end else begin
        e = exp_q.pop_front();
        if (a !== e || frame_tick !== 1'b1) begin
          failures++;
          $display("FAIL tick actual(cyc=%0d upd=%0b fn=%0d fc=%0d cc=%0d pa=%0d ft=%0b) expected(cyc=%0d upd=%0b fn=%0d fc=%0d cc=%0d pa=%0d ft=1)",
                   a[EW-1 -: 32], a[EW-33], a[CW+CW+SW +: FW], a[CW+CW +: SW],
                   a[CW +: CW], a[CW-1:0], frame_tick,
                   e[EW-1 -: 32], e[EW-33], e[CW+CW+SW +: FW], e[CW+CW +: SW],
                   e[CW +: CW], e[CW-1:0]);
        end
      end
    end
  end

  // Stimulus
  initial begin
    int b;
    int p;
    int r;
    resetn      = 1'b0;
    enable      = 1'b0;
    pause       = 1'b0;
    step        = 1'b0;
    period_load = 1'b0;
    period_in   = '0;
    skip_count  = '0;

    // Reset state
    go_to(3);
    chk("rst_cycle_count", 32'(cycle_count), 0);
    chk("rst_frame_count", 32'(frame_count), 0);
    chk("rst_frame_number", 32'(frame_number), 0);
    chk("rst_period_active", 32'(period_active), 9);
    chk("rst_ticks", {30'd0, frame_tick, update_tick}, 0);
    resetn = 1'b1;
    go_to(5);
    chk("disabled_hold", 32'(cycle_count), 0);

    // Period 9, skip 0: ticks 10 cycles apart, counter 9..0
    b = cyc;
    enable = 1'b1;
    push_exp(b + 1,  1'b1, 4'd1, 4'd0, 8'd9, 8'd9);
    push_exp(b + 11, 1'b1, 4'd2, 4'd0, 8'd9, 8'd9);
    push_exp(b + 21, 1'b1, 4'd3, 4'd0, 8'd9, 8'd9);
    for (int i = 0; i < 10; i++) begin
      go_to(b + 1 + i);
      chk("countdown", 32'(cycle_count), 32'(9 - i));
    end
    go_to(b + 21);

    // Skip 2: update on every third frame, frame_count 2,1,0,2
    b = cyc;
    skip_count = 4'd2;
    push_exp(b + 10, 1'b1, 4'd4, 4'd2, 8'd9, 8'd9);
    push_exp(b + 20, 1'b0, 4'd4, 4'd1, 8'd9, 8'd9);
    push_exp(b + 30, 1'b0, 4'd4, 4'd0, 8'd9, 8'd9);
    push_exp(b + 40, 1'b1, 4'd5, 4'd2, 8'd9, 8'd9);
    go_to(b + 40);
    skip_count = 4'd0;
    push_exp(b + 50, 1'b0, 4'd5, 4'd1, 8'd9, 8'd9);
    push_exp(b + 60, 1'b0, 4'd5, 4'd0, 8'd9, 8'd9);
    push_exp(b + 70, 1'b1, 4'd6, 4'd0, 8'd9, 8'd9);
    go_to(b + 70);

    // Period loads: mid-frame, on a reload edge, and back-to-back
    b = cyc;
    push_exp(b + 10, 1'b1, 4'd7,  4'd0, 8'd4, 8'd4);
    push_exp(b + 15, 1'b1, 4'd8,  4'd0, 8'd4, 8'd4);
    push_exp(b + 20, 1'b1, 4'd9,  4'd0, 8'd4, 8'd4);
    push_exp(b + 25, 1'b1, 4'd10, 4'd0, 8'd7, 8'd7);
    push_exp(b + 33, 1'b1, 4'd11, 4'd0, 8'd9, 8'd9);
    push_exp(b + 43, 1'b1, 4'd12, 4'd0, 8'd9, 8'd9);
    go_to(b + 4);
    chk("load_at_5", 32'(cycle_count), 5);
    period_load = 1'b1; period_in = 8'd4;
    go_to(b + 5);
    period_load = 1'b0;
    go_to(b + 9);
    chk("old_period_kept", 32'(period_active), 9);
    go_to(b + 19);
    period_load = 1'b1; period_in = 8'd7;
    go_to(b + 20);
    period_load = 1'b0;
    go_to(b + 26);
    period_load = 1'b1; period_in = 8'd2;
    go_to(b + 27);
    period_in = 8'd9;
    go_to(b + 28);
    period_load = 1'b0;
    go_to(b + 43);

    // Pause at count 3, single step, resume; step while running ignored
    b = cyc;
    go_to(b + 6);
    pause = 1'b1;
    go_to(b + 56);
    chk("pause_cycle_count", 32'(cycle_count), 3);
    chk("pause_frame_number", 32'(frame_number), 12);
    p = cyc;
    push_exp(p + 1,  1'b1, 4'd13, 4'd0, 8'd9, 8'd9);
    push_exp(p + 16, 1'b1, 4'd14, 4'd0, 8'd9, 8'd9);
    push_exp(p + 26, 1'b1, 4'd15, 4'd0, 8'd9, 8'd9);
    push_exp(p + 36, 1'b1, 4'd0,  4'd0, 8'd9, 8'd9);
    push_exp(p + 46, 1'b1, 4'd1,  4'd0, 8'd9, 8'd9);
    step = 1'b1;
    go_to(p + 5);
    step = 1'b0;
    chk("step_reload", 32'(cycle_count), 9);
    go_to(p + 6);
    pause = 1'b0;
    go_to(p + 7);
    chk("resume_count", 32'(cycle_count), 8);
    go_to(p + 8);
    step = 1'b1;
    go_to(p + 9);
    step = 1'b0;
    chk("step_ignored_running", 32'(cycle_count), 6);
    go_to(p + 46);

    // Disable mid-frame: everything holds, load still captured, step ignored
    b = cyc;
    go_to(b + 3);
    enable = 1'b0;
    go_to(b + 5);
    period_load = 1'b1; period_in = 8'd5;
    go_to(b + 6);
    period_load = 1'b0;
    go_to(b + 7);
    pause = 1'b1;
    go_to(b + 8);
    step = 1'b1;
    go_to(b + 9);
    step = 1'b0;
    go_to(b + 10);
    pause = 1'b0;
    go_to(b + 23);
    chk("disable_cycle_count", 32'(cycle_count), 6);
    chk("disable_frame_number", 32'(frame_number), 1);
    chk("disable_period_active", 32'(period_active), 9);
    enable = 1'b1;
    push_exp(b + 30, 1'b1, 4'd2, 4'd0, 8'd5, 8'd5);
    push_exp(b + 36, 1'b1, 4'd3, 4'd0, 8'd5, 8'd5);
    go_to(b + 36);

    // Asynchronous reset while the tick pulses are high
    #1;
    resetn = 1'b0;
    #1;
    chk("async_cycle_count", 32'(cycle_count), 0);
    chk("async_frame_number", 32'(frame_number), 0);
    chk("async_period_active", 32'(period_active), 9);
    chk("async_ticks", {30'd0, frame_tick, update_tick}, 0);
    @(negedge clk);
    @(negedge clk);
    r = cyc;
    resetn = 1'b1;
    push_exp(r + 1, 1'b1, 4'd1, 4'd0, 8'd9, 8'd9);
    go_to(r + 2);
    chk("post_reset_count", 32'(cycle_count), 8);
    go_to(r + 5);
    chk("exp_q_drained", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frame_pacer.md
Name: frame_pacer

Overview:
- Parametrised frame-timing generator, successor to the fixed 30/60 FPS delay counters and the frame skipper.
- Combines a runtime-reprogrammable cycle divider, frame skipper, pause/single-step control and a wrapping update counter in one block.
- Sits between the 50 MHz system clock and game-logic/VGA-draw FSMs, which consume its update_tick as the "advance one game frame" strobe.

Parameters:
- CLK_HZ, 50000000, input clock frequency in Hz.
- FPS, 60, default frame rate; DEFAULT_PERIOD = CLK_HZ/FPS - 1 (833332 at defaults).
- CNT_W, 21, cycle counter width; must hold DEFAULT_PERIOD.
- SKIP_W, 4, skip counter width.
- FRAME_W, 16, update counter width.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- resetn  in  1  asynchronous active-low reset.
- enable  in  1  global run enable; 0 freezes all state.
- pause  in  1  1 = hold counters, allow single-step.
- step  in  1  single-step request; internally rising-edge detected.
- period_load  in  1  one-cycle strobe capturing period_in.
- period_in  in  CNT_W  new divider period (cycles per frame minus 1).
- skip_count  in  SKIP_W  frames skipped between update ticks.
- cycle_count  out  CNT_W  current down-counter value.
- frame_tick  out  1  one-cycle pulse per divider frame.
- update_tick  out  1  one-cycle pulse per non-skipped frame.
- frame_count  out  SKIP_W  current skip down-counter value.
- frame_number  out  FRAME_W  count of update_ticks, wraps.
- period_active  out  CNT_W  period used by the current frame.

Behaviour:
- Reset (async, resetn=0): cycle_count=0, frame_count=0, frame_number=0, frame_tick=0, update_tick=0, period_active=DEFAULT_PERIOD, shadow=DEFAULT_PERIOD, pending=0, step edge register=0. Deasserting reset takes effect at the next clk edge.
- Run condition: run = enable & !pause.
- Frame event: fires on an edge where (run & cycle_count==0), or (enable & pause & rising edge of step).
- At a frame event:
  - If pending: period_active<=shadow and pending<=0.
  - cycle_count<=the new period_active value.
  - frame_tick<=1.
  - Skip logic: if frame_count==0 then frame_count<=skip_count (sampled this edge), update_tick<=1, frame_number<=frame_number+1 (mod 2^FRAME_W); else frame_count<=frame_count-1 and update_tick<=0.
- Run without frame event: cycle_count<=cycle_count-1.
- frame_tick and update_tick are 0 on every edge without a frame event; both are exactly one cycle wide.
- Latency: pulses are registered and appear the cycle after the edge where cycle_count==0 was seen. Tick spacing is period_active+1 cycles.
- First tick after reset: counter starts at 0, so the first enabled run edge produces a frame event and an update_tick (frame_number becomes 1).
- period_load: shadow<=period_in, pending<=1; new value applies from the next frame event, so the frame in progress is never shortened.
  - period_load coinciding with a frame event: the reload uses the prior shadow/active value; the new value stays pending for the following event.
  - Successive loads before a frame event: the last load wins.
- period 0: frame event every run cycle, frame_tick held high continuously (legal).
- skip_count 0: every frame_tick is accompanied by update_tick. skip_count changes take effect only when frame_count reloads.
- pause=1: cycle_count and frame_count hold; period_load still captured.
  - Each step rising edge causes exactly one frame event. step held high yields one event.
  - step while pause=0 is ignored (the edge register still tracks it).
- enable=0: everything holds, step ignored, period_load still captured; enable has priority over pause/step.
- Reset mid-frame: immediate return to reset values; pulses drop asynchronously.

Test Plan:
- CLK_HZ=100, FPS=10 (period 9), skip 0, enable=1 after reset -> frame_tick/update_tick at cycles 1, 11, 21; cycle_count sequence 9..0; frame_number 1,2,3.
- skip_count=2 -> update_tick on every 3rd frame_tick only; frame_count sequence 2,1,0,2; frame_number increments once per 3 frames.
- period_load period_in=4 while cycle_count=5 -> current frame runs to 0 (6 more cycles); subsequent ticks 5 cycles apart; period_active=4 from that event. Also assert load on the reload edge -> new value applies one frame later.
- pause=1 mid-frame at cycle_count=3 -> no ticks for 50 cycles, count frozen at 3. step held high 5 cycles -> exactly one frame_tick, cycle_count=9. pause=0 -> resumes counting down from 9.
- FRAME_W=4, skip 0, run 17 frames -> frame_number wraps 15->0->1. enable=0 mid-frame -> all outputs hold.
- Assert resetn=0 asynchronously mid-frame (between clk edges) -> outputs return to reset values before the next edge; period_active=9 even after an earlier period_load.
